// File: rtl/match_state_fsm.sv
// Match sequencer for a two-player game: IDLE -> SERVE -> PLAY, with pause, scoring and
// match-over handling. Every output comes from a register, so each output changes one clock after its cause.
module match_state_fsm #(
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 6,
  parameter int SERVE_DELAY = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause_btn,
  input  logic               point_p1,
  input  logic               point_p2,
  input  logic               timer_zero,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic [2:0]         game_state,
  output logic               game_active,
  output logic               game_over,
  output logic [1:0]         winner,
  output logic               serve_dir
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SERVE  = 3'd1,
    S_PLAY   = 3'd2,
    S_PAUSED = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam int                  CNT_W    = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
  localparam logic [CNT_W-1:0]    CNT_LOAD = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0]  WIN      = SCORE_W'(WIN_SCORE);

  state_t               r_state, r_ret_state, w_state, w_ret_state;
  logic [SCORE_W-1:0]   r_score_p1, r_score_p2, w_score_p1, w_score_p2;
  logic [SCORE_W-1:0]   w_inc_p1, w_inc_p2;
  logic [CNT_W-1:0]     r_cnt, w_cnt;
  logic [1:0]           r_winner, w_winner, w_tz_winner;
  logic                 r_serve_dir, w_serve_dir;
  logic                 r_active, r_over, w_active, w_over;
  logic                 r_start_q, r_pause_q, r_start_armed;
  logic                 w_start_edge, w_pause_edge;

  // A start held through reset release is not an edge: edges count only once start has been seen low.
  assign w_start_edge = start & ~r_start_q & r_start_armed;
  assign w_pause_edge = pause_btn & ~r_pause_q;
  assign w_inc_p1     = r_score_p1 + SCORE_W'(1);
  assign w_inc_p2     = r_score_p2 + SCORE_W'(1);
  assign w_tz_winner  = (r_score_p1 > r_score_p2) ? 2'b01 :
                        (r_score_p2 > r_score_p1) ? 2'b10 : 2'b11;

  // NOTE: every signal assigned in this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_state     = r_state;
    w_ret_state = r_ret_state;
    w_score_p1  = r_score_p1;
    w_score_p2  = r_score_p2;
    w_cnt       = r_cnt;
    w_winner    = r_winner;
    w_serve_dir = r_serve_dir;
    unique case (r_state)
      S_IDLE: if (w_start_edge) begin
        w_score_p1  = '0;
        w_score_p2  = '0;
        w_winner    = 2'b00;
        w_serve_dir = 1'b0;
        w_cnt       = CNT_LOAD;
        w_state     = S_SERVE;
      end
      S_SERVE: begin
        if (timer_zero) begin
          w_state  = S_OVER;
          w_winner = w_tz_winner;
        end else if (w_pause_edge) begin
          w_ret_state = S_SERVE;
          w_state     = S_PAUSED;
        end else if (r_cnt == '0) begin
          w_state = S_PLAY;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      S_PLAY: begin
        if (timer_zero) begin
          w_state  = S_OVER;
          w_winner = w_tz_winner;
        end else if (point_p1 && point_p2) begin
          w_state = S_SERVE;
          w_cnt   = CNT_LOAD;
        end else if (point_p1) begin
          w_score_p1 = w_inc_p1;
          if (w_inc_p1 == WIN) begin
            w_state  = S_OVER;
            w_winner = 2'b01;
          end else begin
            w_serve_dir = 1'b1;
            w_state     = S_SERVE;
            w_cnt       = CNT_LOAD;
          end
        end else if (point_p2) begin
          w_score_p2 = w_inc_p2;
          if (w_inc_p2 == WIN) begin
            w_state  = S_OVER;
            w_winner = 2'b10;
          end else begin
            w_serve_dir = 1'b0;
            w_state     = S_SERVE;
            w_cnt       = CNT_LOAD;
          end
        end else if (w_pause_edge) begin
          w_ret_state = S_PLAY;
          w_state     = S_PAUSED;
        end
      end
      S_PAUSED: begin
        if (timer_zero) begin
          w_state  = S_OVER;
          w_winner = w_tz_winner;
        end else if (w_pause_edge) begin
          w_state = r_ret_state;
        end
      end
      S_OVER: if (w_start_edge) begin
        w_score_p1  = '0;
        w_score_p2  = '0;
        w_winner    = 2'b00;
        w_serve_dir = 1'b0;
        w_state     = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
    w_active = (w_state == S_PLAY);
    w_over   = (w_state == S_OVER);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_ret_state   <= S_SERVE;
      r_score_p1    <= '0;
      r_score_p2    <= '0;
      r_cnt         <= '0;
      r_winner      <= 2'b00;
      r_serve_dir   <= 1'b0;
      r_active      <= 1'b0;
      r_over        <= 1'b0;
      r_start_q     <= 1'b0;
      r_pause_q     <= 1'b0;
      r_start_armed <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_ret_state   <= w_ret_state;
      r_score_p1    <= w_score_p1;
      r_score_p2    <= w_score_p2;
      r_cnt         <= w_cnt;
      r_winner      <= w_winner;
      r_serve_dir   <= w_serve_dir;
      r_active      <= w_active;
      r_over        <= w_over;
      r_start_q     <= start;
      r_pause_q     <= pause_btn;
      r_start_armed <= r_start_armed | ~start;
    end
  end

  assign score_p1    = r_score_p1;
  assign score_p2    = r_score_p2;
  assign game_state  = r_state;
  assign game_active = r_active;
  assign game_over   = r_over;
  assign winner      = r_winner;
  assign serve_dir   = r_serve_dir;

endmodule

// File: tb/tb_match_state_fsm.sv
// Bench for match_state_fsm: a rule-level match model is compared every cycle, plus directed
// scenarios with hand-computed expectations for serve timing, scoring, pause, draw and reset.
module tb_match_state_fsm;
  localparam int SCORE_W     = 4;
  localparam int WIN_SCORE   = 6;
  localparam int SERVE_DELAY = 4;
  localparam int OUT_W       = 2 * SCORE_W + 8;

  logic clk = 1'b0, reset = 1'b0, start = 1'b0, pause_btn = 1'b0;
  logic point_p1 = 1'b0, point_p2 = 1'b0, timer_zero = 1'b0;
  logic [SCORE_W-1:0] score_p1, score_p2;
  logic [2:0]         game_state;
  logic               game_active, game_over, serve_dir;
  logic [1:0]         winner;

  int n_checks = 0;
  int n_errors = 0;

  match_state_fsm #(.SCORE_W(SCORE_W), .WIN_SCORE(WIN_SCORE), .SERVE_DELAY(SERVE_DELAY)) dut (
    .clk(clk), .reset(reset), .start(start), .pause_btn(pause_btn),
    .point_p1(point_p1), .point_p2(point_p2), .timer_zero(timer_zero),
    .score_p1(score_p1), .score_p2(score_p2), .game_state(game_state),
    .game_active(game_active), .game_over(game_over), .winner(winner), .serve_dir(serve_dir)
  );

  always #5 clk = ~clk;

  // Match model: st uses the published game_state numbering; left = SERVE cycles still to spend.
  typedef struct {
    int st; int s1; int s2; int left; int ret; int dir; int win;
  } mdl_t;

  mdl_t m = '{0, 0, 0, 0, 1, 0, 0};
  bit   m_sq = 1'b0, m_pq = 1'b0, m_seen_low = 1'b0;

  function automatic int score_winner(int a, int b);
    return (a > b) ? 1 : (b > a) ? 2 : 3;
  endfunction

  function automatic mdl_t next_m(mdl_t c, bit se, bit pe, bit p1, bit p2, bit tz);
    mdl_t n = c;
    case (c.st)
      0: if (se) begin
        n.s1 = 0; n.s2 = 0; n.win = 0; n.dir = 0; n.left = SERVE_DELAY; n.st = 1;
      end
      1: if (tz) begin
        n.st = 4; n.win = score_winner(c.s1, c.s2);
      end else if (pe) begin
        n.ret = 1; n.st = 3;
      end else if (c.left == 1) n.st = 2;
      else n.left = c.left - 1;
      2: if (tz) begin
        n.st = 4; n.win = score_winner(c.s1, c.s2);
      end else if (p1 && p2) begin
        n.st = 1; n.left = SERVE_DELAY;
      end else if (p1 || p2) begin
        if (p1) n.s1 = c.s1 + 1; else n.s2 = c.s2 + 1;
        if (n.s1 == WIN_SCORE) begin n.st = 4; n.win = 1; end
        else if (n.s2 == WIN_SCORE) begin n.st = 4; n.win = 2; end
        else begin n.dir = p1 ? 1 : 0; n.st = 1; n.left = SERVE_DELAY; end
      end else if (pe) begin
        n.ret = 2; n.st = 3;
      end
      3: if (tz) begin
        n.st = 4; n.win = score_winner(c.s1, c.s2);
      end else if (pe) n.st = c.ret;
      4: if (se) begin
        n.s1 = 0; n.s2 = 0; n.win = 0; n.dir = 0; n.st = 0;
      end
      default: n.st = 0;
    endcase
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m          <= '{0, 0, 0, 0, 1, 0, 0};
      m_sq       <= 1'b0;
      m_pq       <= 1'b0;
      m_seen_low <= 1'b0;
    end else begin
      m          <= next_m(m, start && !m_sq && m_seen_low, pause_btn && !m_pq,
                           point_p1, point_p2, timer_zero);
      m_sq       <= start;
      m_pq       <= pause_btn;
      m_seen_low <= m_seen_low | ~start;
    end
  end

  always @(negedge clk) begin
    logic [OUT_W-1:0] act, exp;
    act = {score_p1, score_p2, game_state, game_active, game_over, winner, serve_dir};
    exp = {SCORE_W'(m.s1), SCORE_W'(m.s2), 3'(m.st), (m.st == 2), (m.st == 4), 2'(m.win), 1'(m.dir)};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL model_cmp t=%0t actual=%h expected=%h", $time, act, exp);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_edge();
    start = 1'b0; step();
    start = 1'b1; step();
  endtask

  task automatic pulse(input bit p1, input bit p2);
    point_p1 = p1; point_p2 = p2; step();
    point_p1 = 1'b0; point_p2 = 1'b0;
  endtask

  task automatic wait_play();
    for (int i = 0; i < 30; i++) begin
      if (game_state == 3'd2) break;
      step();
    end
    check("wait_play", game_state, 2);
  endtask

  initial begin
    #1 reset = 1'b1; start = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    check("start_held_through_reset", game_state, 0);

    start_edge();
    check("serve_entry", game_state, 1);
    step(3);
    check("serve_4th_cycle", game_state, 1);
    step();
    check("play_after_4", game_state, 2);
    check("game_active", game_active, 1);

    for (int k = 1; k <= 5; k++) begin
      pulse(1, 0);
      check("p1_score", score_p1, k);
      check("p1_serve_dir", serve_dir, 1);
      wait_play();
    end
    pulse(1, 0);
    check("win_state", game_state, 4);
    check("win_winner", winner, 1);
    check("win_game_over", game_over, 1);
    check("win_score", score_p1, 6);

    start_edge();
    check("over_to_idle", game_state, 0);
    check("idle_score_p1", score_p1, 0);
    check("idle_winner", winner, 0);

    start_edge();
    step();
    pause_btn = 1'b1; step();
    check("paused", game_state, 3);
    step(10);
    check("paused_after_10", game_state, 3);
    pause_btn = 1'b0; step();
    pause_btn = 1'b1; step();
    check("resume_serve", game_state, 1);
    step(2);
    check("resume_serve_2", game_state, 1);
    step();
    check("resume_play_3", game_state, 2);
    pause_btn = 1'b0;

    pulse(1, 1);
    check("replay_state", game_state, 1);
    check("replay_s1", score_p1, 0);
    check("replay_s2", score_p2, 0);
    wait_play();

    for (int k = 0; k < 3; k++) begin
      pulse(1, 0); wait_play();
      pulse(0, 1);
      check("p2_serve_dir", serve_dir, 0);
      wait_play();
    end
    check("draw_s1", score_p1, 3);
    check("draw_s2", score_p2, 3);
    timer_zero = 1'b1; step(); timer_zero = 1'b0;
    check("draw_state", game_state, 4);
    check("draw_winner", winner, 3);
    start_edge();
    check("draw_idle", game_state, 0);
    check("draw_idle_s2", score_p2, 0);

    start_edge(); wait_play();
    for (int k = 0; k < 5; k++) begin pulse(1, 0); wait_play(); end
    point_p1 = 1'b1; timer_zero = 1'b1; step();
    point_p1 = 1'b0; timer_zero = 1'b0;
    check("tz_beats_win_state", game_state, 4);
    check("tz_beats_win_score", score_p1, 5);
    check("tz_beats_win_winner", winner, 1);

    start_edge();
    start_edge(); wait_play();
    for (int k = 0; k < 4; k++) begin pulse(1, 0); wait_play(); end
    for (int k = 0; k < 2; k++) begin pulse(0, 1); wait_play(); end
    pause_btn = 1'b1; step();
    check("rst_paused", game_state, 3);
    check("rst_pre_s1", score_p1, 4);
    check("rst_pre_s2", score_p2, 2);
    #2 reset = 1'b1;
    #1;
    check("rst_async_all",
          {score_p1, score_p2, game_state, game_active, game_over, winner, serve_dir}, 0);
    step();
    reset = 1'b0; pause_btn = 1'b0;
    step(3);
    check("rst_needs_fresh_start", game_state, 0);
    start_edge();
    check("rst_fresh_start", game_state, 1);
    step(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/match_state_fsm.md
MATCH_STATE_FSM -- requirements
Module: match_state_fsm

Interface
REQ-001 Parameter SCORE_W, default 4: width of each player score.
REQ-002 Parameter WIN_SCORE, default 6: score that ends the match; legal range 1 to 2^SCORE_W-1.
REQ-003 Parameter SERVE_DELAY, default 50: number of clk cycles spent in SERVE before PLAY; legal range at least 1.
REQ-004 Port clk, input, 1: single system clock; every register is on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port start, input, 1: level button; its rising edge starts or restarts a match.
REQ-007 Port pause_btn, input, 1: level switch; each rising edge toggles pause.
REQ-008 Port point_p1 / point_p2, input, 1 each: single-cycle pulses from ball logic, "P1 scored" and "P2 scored".
REQ-009 Port timer_zero, input, 1: match clock has expired.
REQ-010 Port score_p1 / score_p2, output, SCORE_W each: registered scores.
REQ-011 Port game_state, output, 3: 0=IDLE, 1=SERVE, 2=PLAY, 3=PAUSED, 4=OVER.
REQ-012 Port game_active, output, 1: high only in PLAY.
REQ-013 Port game_over, output, 1: high only in OVER.
REQ-014 Port winner, output, 2: 00=none, 01=P1, 10=P2, 11=draw.
REQ-015 Port serve_dir, output, 1: 0 = serve toward P1, 1 = serve toward P2.

Function
REQ-016 All outputs are registered; the response to a sampled input appears on the next rising clk edge (1-cycle latency).
REQ-017 start and pause_btn edge detection uses the input registered on the previous cycle; an edge is current=1 and previous=0.
REQ-018 IDLE: a start edge clears both scores, sets winner=00 and serve_dir=0, loads the serve counter with SERVE_DELAY-1, and moves to SERVE. All other inputs are ignored.
REQ-019 SERVE: the counter decrements once per cycle; at 0 the FSM moves to PLAY. Point pulses are ignored in SERVE.
REQ-020 PLAY, single point pulse: the scorer's score increments by 1.
- New score == WIN_SCORE: go to OVER with winner = scorer.
- Otherwise: go to SERVE, reload the counter, set serve_dir toward the player who conceded.
REQ-021 PLAY, point_p1 and point_p2 both high in the same cycle: neither score changes, serve_dir is unchanged, and the FSM moves to SERVE (replay).
REQ-022 A pause edge in SERVE or PLAY moves the FSM to PAUSED and records the state it left. The serve counter and scores hold.
REQ-023 PAUSED: a pause edge returns to the recorded state with the counter resumed where it stopped. Point pulses are ignored in PAUSED.
REQ-024 timer_zero high in SERVE, PLAY or PAUSED moves the FSM to OVER. winner = the player with the higher score, or 11 if scores are equal.
REQ-025 Priority within a cycle, highest first: timer_zero, point pulse, pause edge, serve-counter expiry.
REQ-026 A point that reaches WIN_SCORE in the same cycle as timer_zero is not counted; winner is decided per REQ-024 on the old scores.
REQ-027 OVER: scores and winner hold. A start edge moves to IDLE with scores cleared, winner=00 and serve_dir=0. No other input has any effect.
REQ-028 Scores never exceed WIN_SCORE and never wrap.
REQ-029 An unused game_state encoding (5-7) returns to IDLE on the next cycle.

Reset
REQ-030 While reset is high, independent of clk: game_state=IDLE, score_p1=score_p2=0, winner=00, serve_dir=0, game_active=0, game_over=0, serve counter=0, recorded pause state=SERVE, and both edge-detect registers=0.
REQ-031 Reset asserted mid-match (any state, including PAUSED) discards all match data. After release, the FSM requires a fresh start edge.
REQ-032 A start held high through reset release does not count as an edge.

Verification
REQ-033 SERVE_DELAY=4: start edge in IDLE -> SERVE for exactly 4 cycles, then PLAY with game_active=1.
REQ-034 Five point_p1 pulses in PLAY -> score_p1=5, serve_dir=1 after each. A sixth pulse -> OVER, winner=01, game_over=1, score_p1=6.
REQ-035 Pause edge with the serve counter at 2 -> PAUSED for 10 cycles with the counter held. Second pause edge -> SERVE, and PLAY follows 3 cycles later.
REQ-036 point_p1 and point_p2 pulsed in the same cycle in PLAY -> scores unchanged, SERVE entered.
REQ-037 Scores 3-3, timer_zero asserted in PLAY -> OVER, winner=11. Start edge -> IDLE with scores 0.
REQ-038 Reset pulsed at scores 4-2 in PAUSED -> all outputs at reset values within the same cycle, game_state=IDLE.
